// File: rtl/spk_stream_arb_if.sv
// Spike stream bundle between the detector banks, the arbiter and the classifier queue.
// The master modport is the merging side (arbiter); the slave modport is its environment.
interface spk_stream_if #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 96,
    parameter int SRC_W   = 2
);
    logic [NUM_SRC-1:0]        s_tvalid;
    logic [NUM_SRC-1:0]        s_tready;
    logic [6*NUM_SRC-1:0]      s_ch;
    logic [32*NUM_SRC-1:0]     s_time;
    logic [16*NUM_SRC-1:0]     s_tdest;
    logic [DATA_W*NUM_SRC-1:0] s_tdata;

    logic                      m_tvalid;
    logic                      m_tready;
    logic [5:0]                m_ch;
    logic [31:0]               m_time;
    logic [15:0]               m_tdest;
    logic [DATA_W-1:0]         m_tdata;
    logic [SRC_W-1:0]          m_src;
    logic                      m_tlast;

    modport master (
        input  s_tvalid, s_ch, s_time, s_tdest, s_tdata, m_tready,
        output s_tready, m_tvalid, m_ch, m_time, m_tdest, m_tdata, m_src, m_tlast
    );

    modport slave (
        output s_tvalid, s_ch, s_time, s_tdest, s_tdata, m_tready,
        input  s_tready, m_tvalid, m_ch, m_time, m_tdest, m_tdata, m_src, m_tlast
    );
endinterface

// File: rtl/spk_stream_arb.sv
// Round-robin packet arbiter merging NUM_SRC spike-waveform streams into one,
// locking each grant for a full SPK_LENTH-beat packet, with a one-deep output register.
//
// state | meaning
// IDLE  | no grant; pick next requester after r_ptr
// BURST | packet from r_grant in flight until its last beat is accepted
module spk_stream_arb #(
    parameter int NUM_SRC   = 4,
    parameter int SPK_LENTH = 19,
    parameter int DATA_W    = 96,
    parameter int SRC_W     = $clog2(NUM_SRC)
) (
    input  logic        clk,
    input  logic        rst_n,
    spk_stream_if.master bus,
    output logic        pkt_pulse,
    output logic [31:0] pkt_cnt,
    output logic        err_tdest
);
    typedef enum logic {IDLE, BURST} state_t;

    localparam logic [15:0]      LAST_BEAT = 16'(SPK_LENTH - 1);
    localparam logic [SRC_W-1:0] PTR_RST   = SRC_W'(NUM_SRC - 1);

    state_t             r_state, w_state_nxt;
    logic [SRC_W-1:0]   r_grant, r_ptr, w_pick, w_cand;
    logic [15:0]        r_beat_cnt;
    logic               w_any, w_out_free, w_accept, w_last_beat;

    logic               r_m_tvalid, r_m_tlast, r_pkt_pulse, r_err;
    logic [SRC_W-1:0]   r_m_src;
    logic [5:0]         r_m_ch;
    logic [31:0]        r_m_time, r_pkt_cnt;
    logic [15:0]        r_m_tdest;
    logic [DATA_W-1:0]  r_m_tdata;

    // Scan from the farthest offset down so the nearest requester after r_ptr wins.
    always_comb begin
        w_pick = r_ptr;
        w_cand = r_ptr;
        w_any  = 1'b0;
        for (int i = NUM_SRC; i >= 1; i--) begin
            w_cand = SRC_W'((int'(r_ptr) + i) % NUM_SRC);
            if (bus.s_tvalid[w_cand]) begin
                w_pick = w_cand;
                w_any  = 1'b1;
            end
        end
    end

    assign w_out_free  = !r_m_tvalid || bus.m_tready;
    assign w_last_beat = (r_beat_cnt == LAST_BEAT);
    assign w_accept    = (r_state == BURST) && bus.s_tvalid[r_grant] && w_out_free;

    always_comb begin
        w_state_nxt  = r_state;
        bus.s_tready = '0;
        case (r_state)
            IDLE: begin
                if (w_any) w_state_nxt = BURST;
            end
            BURST: begin
                bus.s_tready[r_grant] = w_out_free;
                if (w_accept && w_last_beat) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_ptr      <= PTR_RST;
            r_beat_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_any) begin
                r_grant    <= w_pick;
                r_beat_cnt <= '0;
            end else if (w_accept) begin
                if (w_last_beat) begin
                    r_ptr      <= r_grant;
                    r_beat_cnt <= '0;
                end else begin
                    r_beat_cnt <= r_beat_cnt + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_tvalid  <= 1'b0;
            r_m_tlast   <= 1'b0;
            r_m_src     <= '0;
            r_m_ch      <= '0;
            r_m_time    <= '0;
            r_m_tdest   <= '0;
            r_m_tdata   <= '0;
            r_pkt_pulse <= 1'b0;
            r_pkt_cnt   <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_m_tvalid <= 1'b1;
                r_m_tlast  <= w_last_beat;
                r_m_src    <= r_grant;
                r_m_ch     <= bus.s_ch[r_grant*6 +: 6];
                r_m_time   <= bus.s_time[r_grant*32 +: 32];
                r_m_tdest  <= bus.s_tdest[r_grant*16 +: 16];
                r_m_tdata  <= bus.s_tdata[r_grant*DATA_W +: DATA_W];
            end else if (bus.m_tready) begin
                r_m_tvalid <= 1'b0;
            end
            r_pkt_pulse <= w_accept && (r_beat_cnt == 16'd0);
            if (r_m_tvalid && bus.m_tready && r_m_tlast) r_pkt_cnt <= r_pkt_cnt + 32'd1;
            // Framing follows the beat counter; a TDEST mismatch is only flagged.
            if (w_accept && (bus.s_tdest[r_grant*16 +: 16] != r_beat_cnt)) r_err <= 1'b1;
        end
    end

    assign bus.m_tvalid = r_m_tvalid;
    assign bus.m_tlast  = r_m_tlast;
    assign bus.m_src    = r_m_src;
    assign bus.m_ch     = r_m_ch;
    assign bus.m_time   = r_m_time;
    assign bus.m_tdest  = r_m_tdest;
    assign bus.m_tdata  = r_m_tdata;
    assign pkt_pulse    = r_pkt_pulse;
    assign pkt_cnt      = r_pkt_cnt;
    assign err_tdest    = r_err;
endmodule
